// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle logic/arithmetic ops plus an iterative
// shift-add unsigned multiply, with valid/ready handshakes on both sides.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam int         CW       = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               zero_q;
  logic               overflow_q;
  logic               illegal_q;
  logic [WIDTH-1:0]   result_q;
  logic [WIDTH-1:0]   result_hi_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CW-1:0]      cnt_q;

  logic [WIDTH-1:0]   sum_s;
  logic [WIDTH-1:0]   diff_s;
  logic [WIDTH-1:0]   alu_res_d;
  logic               alu_ovf_d;
  logic               alu_ill_d;
  logic               alu_mul_d;
  logic [2*WIDTH-1:0] acc_d;

  assign sum_s  = a + b;
  assign diff_s = a - b;

  // Single-cycle result, overflow and decode of the incoming operation
  always_comb begin
    alu_res_d = {WIDTH{1'b0}};
    alu_ovf_d = 1'b0;
    alu_ill_d = 1'b0;
    alu_mul_d = 1'b0;
    case (operation)
      OP_AND: alu_res_d = a & b;
      OP_OR:  alu_res_d = a | b;
      OP_ADD: begin
        alu_res_d = sum_s;
        alu_ovf_d = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_d = diff_s;
        alu_ovf_d = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT: begin
        // True signed compare so the answer survives a - b overflowing
        if ($signed(a) < $signed(b)) begin
          alu_res_d = {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
          alu_res_d = {WIDTH{1'b0}};
        end
      end
      OP_NOR:   alu_res_d = ~(a | b);
      OP_MULTU: alu_mul_d = 1'b1;
      default:  alu_ill_d = 1'b1;
    endcase
  end

  // Accumulator value after this multiply step
  always_comb begin
    if (mplier_q[0]) begin
      acc_d = acc_q + mcand_q;
    end else begin
      acc_d = acc_q;
    end
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= {WIDTH{1'b0}};
      result_hi_q <= {WIDTH{1'b0}};
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      illegal_q   <= 1'b0;
      mplier_q    <= {WIDTH{1'b0}};
      mcand_q     <= {(2*WIDTH){1'b0}};
      acc_q       <= {(2*WIDTH){1'b0}};
      cnt_q       <= {CW{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (!in_ready_q) begin
            in_ready_q <= 1'b1;
          end else if (in_valid) begin
            in_ready_q <= 1'b0;
            if (alu_mul_d) begin
              mcand_q <= {{WIDTH{1'b0}}, a};
              mplier_q <= b;
              acc_q    <= {(2*WIDTH){1'b0}};
              cnt_q    <= CW'(WIDTH);
              state_q  <= MUL;
            end else begin
              result_q    <= alu_res_d;
              result_hi_q <= {WIDTH{1'b0}};
              zero_q      <= (alu_res_d == {WIDTH{1'b0}});
              overflow_q  <= alu_ovf_d;
              illegal_q   <= alu_ill_d;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            {result_hi_q, result_q} <= acc_d;
            zero_q      <= (acc_d == {(2*WIDTH){1'b0}});
            overflow_q  <= 1'b0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            state_q <= MUL;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end else begin
            state_q <= DONE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign zero      = zero_q;
  assign overflow  = overflow_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: expected results come from a behavioural
// model, are queued at issue and popped when out_valid is observed.
module tb_alu_exec_unit;

  localparam int W = 32;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    operation;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic [W-1:0]  result_hi;
  logic          zero;
  logic          overflow;
  logic          illegal;

  typedef struct packed {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         z;
    logic         ov;
    logic         il;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    tests;
  int    fails;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operation (operation),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .zero      (zero),
    .overflow  (overflow),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t   e;
    longint sx;
    longint sy;
    longint s;
    logic [63:0] p;
    e  = '0;
    sx = $signed(x);
    sy = $signed(y);
    case (op)
      4'b0000: e.res = x & y;
      4'b0001: e.res = x | y;
      4'b0010: begin
        s = sx + sy;
        e.res = s[W-1:0];
        e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0110: begin
        s = sx - sy;
        e.res = s[W-1:0];
        e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0111: e.res = (sx < sy) ? 32'd1 : 32'd0;
      4'b1100: e.res = ~(x | y);
      4'b1000: begin
        p = {32'd0, x} * {32'd0, y};
        e.res = p[31:0];
        e.hi  = p[63:32];
      end
      default: e.il = 1'b1;
    endcase
    e.z = ({e.hi, e.res} == 64'd0);
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input string tag, input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    in_valid  = 1'b1;
    operation = op;
    a         = x;
    b         = y;
    exp_q.push_back(model(op, x, y));
    tag_q.push_back(tag);
  endtask

  // Wait (bounded) for in_ready, let the accept edge pass, leave at the next negedge
  task automatic accept(input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".accept"}, {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic compare_pop();
    exp_t  e;
    string t;
    check("sb.nonempty", {63'd0, exp_q.size() != 0}, 64'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check({t, ".result"},    {32'd0, result},    {32'd0, e.res});
      check({t, ".result_hi"}, {32'd0, result_hi}, {32'd0, e.hi});
      check({t, ".zero"},      {63'd0, zero},      {63'd0, e.z});
      check({t, ".overflow"},  {63'd0, overflow},  {63'd0, e.ov});
      check({t, ".illegal"},   {63'd0, illegal},   {63'd0, e.il});
    end
  endtask

  task automatic wait_out(input string tag, input int exp_lat, output logic rdy_seen);
    int lat;
    lat = 1;
    rdy_seen = in_ready;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
      rdy_seen = rdy_seen | in_ready;
    end
    check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    compare_pop();
  endtask

  task automatic ack(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".valid_drop"}, {63'd0, out_valid}, 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y, input int lat);
    logic rs;
    drive(tag, op, x, y);
    accept(tag);
    wait_out(tag, lat, rs);
    ack(tag);
  endtask

  initial begin
    logic rs;
    tests = 0;
    fails = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    operation = 4'b0000;
    a = '0;
    b = '0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst.in_ready", {63'd0, in_ready}, 64'd0);
      check("rst.out_valid", {63'd0, out_valid}, 64'd0);
    end
    check("rst.outputs", {result, result_hi}, 64'd0);
    check("rst.flags", {61'd0, zero, overflow, illegal}, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst.ready_after", {63'd0, in_ready}, 64'd1);

    run_op("add_ovf",  4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 1);
    run_op("sub_zero", 4'b0110, 32'd5,         32'd5,         1);
    run_op("sub_ovf",  4'b0110, 32'h8000_0000, 32'd1,         1);
    run_op("slt_neg",  4'b0111, 32'h8000_0000, 32'd1,         1);
    run_op("slt_pos",  4'b0111, 32'd1,         32'h8000_0000, 1);
    run_op("nor",      4'b1100, 32'd0,         32'd0,         1);
    run_op("illegal",  4'b0011, 32'h1234_5678, 32'h0000_FFFF, 1);
    run_op("or",       4'b0001, 32'h1234_0000, 32'h0000_F00F, 1);

    drive("mul_max", 4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    accept("mul_max");
    wait_out("mul_max", 33, rs);
    check("mul_max.in_ready_low", {63'd0, rs}, 64'd0);
    check("mul_max.hi_const", {32'd0, result_hi}, 64'hFFFF_FFFE);
    ack("mul_max");
    run_op("mul_zero", 4'b1000, 32'd0,         32'd7,         33);
    run_op("mul_mix",  4'b1000, 32'h1234_5678, 32'h9ABC_DEF0, 33);

    // Back-pressure: hold out_ready low while a new request waits
    drive("bp_add", 4'b0010, 32'd3, 32'd4);
    accept("bp_add");
    wait_out("bp_add", 1, rs);
    in_valid  = 1'b1;
    operation = 4'b0001;
    a = 32'h0000_00F0;
    b = 32'h0000_000F;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp.hold_result", {32'd0, result}, 64'd7);
      check("bp.hold_valid", {63'd0, out_valid}, 64'd1);
      check("bp.in_ready", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp.valid_drop", {63'd0, out_valid}, 64'd0);
    check("bp.ready_back", {63'd0, in_ready}, 64'd1);
    exp_q.push_back(model(4'b0001, 32'h0000_00F0, 32'h0000_000F));
    tag_q.push_back("bp_or");
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_or.valid", {63'd0, out_valid}, 64'd1);
    compare_pop();
    ack("bp_or");

    // Reset in the middle of a multiply aborts it
    drive("mul_abort", 4'b1000, 32'h0000_0003, 32'h0000_0005);
    accept("mul_abort");
    repeat (9) @(negedge clk);
    check("abort.mid_valid", {63'd0, out_valid}, 64'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    void'(exp_q.pop_front());
    void'(tag_q.pop_front());
    check("abort.valid_rst", {63'd0, out_valid}, 64'd0);
    check("abort.ready_rst", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("abort.ready_after", {63'd0, in_ready}, 64'd1);
    check("abort.valid_after", {63'd0, out_valid}, 64'd0);
    run_op("and_after", 4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 1);
    check("and_after.const", {32'd0, result}, 64'h0000_F000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
